generic_write_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream generic write port (slave side of `generic_write_interface`) between NUM_REQ requesters.
- Latches one requester's address/data/size, issues a single-cycle write strobe, then waits for `write_response` or a timeout.
- Returns a done pulse plus an ok/error status to the granted requester.
- Sits between CPU-side masters (core store path, debug/CSR writer) and a shared memory or peripheral write port.

---
 rtl/generic_write_pkg.sv | 16 +
 rtl/rr_priority_picker.sv | 33 +++
 rtl/generic_write_arbiter.sv | 137 +++++++++++++
 tb/tb_generic_write_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/generic_write_pkg.sv
// Shared types and width helpers for the generic write arbiter and its picker.
package generic_write_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } gw_arb_state_t;

    // $clog2 floored at 1 so degenerate parameters never produce zero-width vectors.
    function automatic int gw_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request strictly after `last`, wrapping.
module rr_priority_picker
    import generic_write_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = gw_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] index,
    output logic          any
);

    logic [IW-1:0] cand;

    always_comb begin
        onehot = '0;
        index  = '0;
        any    = 1'b0;
        cand   = '0;
        // Offsets 1..N put the previous owner last in the search order.
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last) + k) % N);
            if (!any && req[cand]) begin
                any          = 1'b1;
                onehot[cand] = 1'b1;
                index        = cand;
            end
        end
    end

endmodule

// File: rtl/generic_write_arbiter.sv
// Round-robin arbiter sharing one generic write port among NUM_REQ requesters,
// with a per-transaction response timeout and ok/error status on completion.
module generic_write_arbiter
    import generic_write_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 256,
    parameter int TIMEOUT = 16,
    localparam int AW = gw_width(DEPTH),
    localparam int SW = gw_width(WIDTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*AW-1:0]    req_address,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ*SW-1:0]    req_size,
    output logic [NUM_REQ-1:0]       req_done,
    output logic                     req_ok,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     write_clock,
    output logic [AW-1:0]            write_address,
    output logic                     write_valid,
    output logic [WIDTH-1:0]         write_data,
    output logic [SW-1:0]            write_size,
    input  logic                     write_response
);

    localparam int IW = gw_width(NUM_REQ);
    localparam int CW = gw_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    gw_arb_state_t      state, state_n;
    logic [NUM_REQ-1:0] grant_n, done_n;
    logic               ok_n, valid_n;
    logic [AW-1:0]      address_n;
    logic [WIDTH-1:0]   data_n;
    logic [SW-1:0]      size_n;
    logic [IW-1:0]      last_grant, last_grant_n;
    logic [IW-1:0]      grant_index, grant_index_n;
    logic [CW-1:0]      count, count_n;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IW-1:0]      pick_index;
    logic               pick_any;

    assign write_clock = clock;

    rr_priority_picker #(.N(NUM_REQ)) picker (
        .req    (req_valid),
        .last   (last_grant),
        .onehot (pick_onehot),
        .index  (pick_index),
        .any    (pick_any)
    );

    always_comb begin
        state_n       = state;
        grant_n       = grant;
        done_n        = '0;
        ok_n          = req_ok;
        valid_n       = 1'b0;
        address_n     = write_address;
        data_n        = write_data;
        size_n        = write_size;
        last_grant_n  = last_grant;
        grant_index_n = grant_index;
        count_n       = count;
        case (state)
            IDLE: begin
                ok_n = 1'b0;
                if (pick_any) begin
                    grant_n       = pick_onehot;
                    grant_index_n = pick_index;
                    address_n     = req_address[pick_index*AW +: AW];
                    data_n        = req_data[pick_index*WIDTH +: WIDTH];
                    size_n        = req_size[pick_index*SW +: SW];
                    valid_n       = 1'b1;
                    state_n       = ISSUE;
                end
            end
            // A response during the strobe cycle is deliberately not sampled.
            ISSUE: state_n = WAIT;
            WAIT: begin
                if (write_response) begin
                    ok_n    = 1'b1;
                    done_n  = grant;
                    state_n = DONE;
                end else if (count == CNT_LAST) begin
                    ok_n    = 1'b0;
                    done_n  = grant;
                    state_n = DONE;
                end else begin
                    count_n = count + 1'b1;
                end
            end
            DONE: begin
                grant_n      = '0;
                ok_n         = 1'b0;
                last_grant_n = grant_index;
                count_n      = '0;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            grant         <= '0;
            req_done      <= '0;
            req_ok        <= 1'b0;
            write_valid   <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            write_size    <= '0;
            last_grant    <= IW'(NUM_REQ - 1);
            grant_index   <= '0;
            count         <= '0;
        end else begin
            state         <= state_n;
            grant         <= grant_n;
            req_done      <= done_n;
            req_ok        <= ok_n;
            write_valid   <= valid_n;
            write_address <= address_n;
            write_data    <= data_n;
            write_size    <= size_n;
            last_grant    <= last_grant_n;
            grant_index   <= grant_index_n;
            count         <= count_n;
        end
    end

endmodule

// File: tb/tb_generic_write_arbiter.sv
// Scoreboard bench for generic_write_arbiter: directed requests, a scripted slave,
// and a negedge monitor comparing every write strobe and done pulse against queues.
module tb_generic_write_arbiter;

    localparam int NUM_REQ = 2;
    localparam int WIDTH   = 8;
    localparam int DEPTH   = 256;
    localparam int TIMEOUT = 4;
    localparam int AW      = 8;
    localparam int SW      = 3;
    localparam int WEW     = NUM_REQ + AW + WIDTH + SW;
    localparam int DEW     = NUM_REQ + 1 + 4;

    logic                     clock;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*AW-1:0]    req_address;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ*SW-1:0]    req_size;
    logic [NUM_REQ-1:0]       req_done;
    logic                     req_ok;
    logic [NUM_REQ-1:0]       grant;
    logic                     write_clock;
    logic [AW-1:0]            write_address;
    logic                     write_valid;
    logic [WIDTH-1:0]         write_data;
    logic [SW-1:0]            write_size;
    logic                     write_response;

    logic             rv [NUM_REQ];
    logic [AW-1:0]    ra [NUM_REQ];
    logic [WIDTH-1:0] rd [NUM_REQ];
    logic [SW-1:0]    rs [NUM_REQ];

    assign req_valid   = {rv[1], rv[0]};
    assign req_address = {ra[1], ra[0]};
    assign req_data    = {rd[1], rd[0]};
    assign req_size    = {rs[1], rs[0]};

    logic [WEW-1:0] wr_exp_q[$];
    logic [DEW-1:0] done_exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_wv_cyc = 0;
    int resp_mode = 0;   // 0: respond one cycle after strobe, 1: never, 2: only during strobe
    logic wv_prev = 1'b0;

    generic_write_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_address    (req_address),
        .req_data       (req_data),
        .req_size       (req_size),
        .req_done       (req_done),
        .req_ok         (req_ok),
        .grant          (grant),
        .write_clock    (write_clock),
        .write_address  (write_address),
        .write_valid    (write_valid),
        .write_data     (write_data),
        .write_size     (write_size),
        .write_response (write_response)
    );

    // Clock/reset block
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Slave model
    initial begin
        write_response = 1'b0;
        forever begin
            @(negedge clock);
            write_response = 1'b0;
            if (wv_prev && resp_mode == 0) write_response = 1'b1;
            if (write_valid === 1'b1 && resp_mode == 2) write_response = 1'b1;
            wv_prev = (write_valid === 1'b1);
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [WEW-1:0] we, wa;
        logic [DEW-1:0] de, da;
        forever begin
            @(negedge clock);
            if (write_valid === 1'b1) begin
                checks++;
                wa = {grant, write_address, write_data, write_size};
                if (wr_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected got grant/addr/data/size=%h required none", wa);
                end else begin
                    we = wr_exp_q.pop_front();
                    if (wa !== we) begin
                        errors++;
                        $display("FAIL write_beat got grant/addr/data/size=%h required %h", wa, we);
                    end
                end
                last_wv_cyc = cyc;
            end
            if (req_done !== '0 && req_done !== 'x) begin
                checks++;
                da = {req_done, req_ok, 4'(cyc - last_wv_cyc)};
                if (done_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected got done/ok/lat=%h required none", da);
                end else begin
                    de = done_exp_q.pop_front();
                    if (da !== de) begin
                        errors++;
                        $display("FAIL done_pulse got done/ok/lat=%h required %h", da, de);
                    end
                end
            end
        end
    end

    // Driver tasks
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, exp);
        end
    endtask

    task automatic exp_write(input logic [NUM_REQ-1:0] g, input logic [AW-1:0] a,
                             input logic [WIDTH-1:0] d, input logic [SW-1:0] s);
        wr_exp_q.push_back({g, a, d, s});
    endtask

    task automatic exp_done(input logic [NUM_REQ-1:0] g, input logic ok, input logic [3:0] lat);
        done_exp_q.push_back({g, ok, lat});
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a,
                           input logic [WIDTH-1:0] d, input logic [SW-1:0] s);
        ra[i] = a;
        rd[i] = d;
        rs[i] = s;
        rv[i] = 1'b1;
    endtask

    task automatic wait_done(input int i);
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clock);
            if (req_done[i] === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_wait requester %0d got no req_done required a pulse within 40 cycles", i);
        end
    endtask

    task automatic wait_wv();
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clock);
            if (write_valid === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL strobe_wait got no write_valid required one within 40 cycles");
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            rv[i] = 1'b0; ra[i] = '0; rd[i] = '0; rs[i] = '0;
        end
        repeat (3) @(negedge clock);
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_write_valid", 32'(write_valid), 32'd0);
        chk("reset_req_done", 32'(req_done), 32'd0);
        chk("reset_req_ok", 32'(req_ok), 32'd0);
        chk("reset_write_address", 32'(write_address), 32'd0);
        chk("reset_write_data", 32'(write_data), 32'd0);
        chk("reset_write_size", 32'(write_size), 32'd0);
        reset = 1'b0;

        // Single request, prompt response
        resp_mode = 0;
        exp_write(2'b01, 8'h12, 8'hA5, 3'd3);
        exp_done(2'b01, 1'b1, 4'd2);
        set_req(0, 8'h12, 8'hA5, 3'd3);
        wait_done(0);
        rv[0] = 1'b0;

        // Contention from reset: grant order 0,1,0,1
        @(negedge clock);
        reset = 1'b1;
        exp_write(2'b01, 8'h30, 8'h01, 3'd1);
        exp_write(2'b10, 8'h31, 8'h02, 3'd2);
        exp_write(2'b01, 8'h32, 8'h03, 3'd3);
        exp_write(2'b10, 8'h33, 8'h04, 3'd4);
        repeat (4) exp_done(2'b00, 1'b1, 4'd2);
        done_exp_q[0][DEW-1 -: NUM_REQ] = 2'b01;
        done_exp_q[1][DEW-1 -: NUM_REQ] = 2'b10;
        done_exp_q[2][DEW-1 -: NUM_REQ] = 2'b01;
        done_exp_q[3][DEW-1 -: NUM_REQ] = 2'b10;
        set_req(0, 8'h30, 8'h01, 3'd1);
        set_req(1, 8'h31, 8'h02, 3'd2);
        @(negedge clock);
        reset = 1'b0;
        fork
            begin
                wait_done(0);
                set_req(0, 8'h32, 8'h03, 3'd3);
                wait_done(0);
                rv[0] = 1'b0;
            end
            begin
                wait_done(1);
                set_req(1, 8'h33, 8'h04, 3'd4);
                wait_done(1);
                rv[1] = 1'b0;
            end
        join

        // Timeout, then a normal transaction
        resp_mode = 1;
        exp_write(2'b10, 8'h40, 8'h3C, 3'd5);
        exp_done(2'b10, 1'b0, 4'd5);
        set_req(1, 8'h40, 8'h3C, 3'd5);
        wait_done(1);
        rv[1] = 1'b0;
        resp_mode = 0;
        exp_write(2'b01, 8'h55, 8'h0F, 3'd1);
        exp_done(2'b01, 1'b1, 4'd2);
        set_req(0, 8'h55, 8'h0F, 3'd1);
        wait_done(0);
        rv[0] = 1'b0;

        // Response only during the strobe cycle is ignored
        resp_mode = 2;
        exp_write(2'b01, 8'h21, 8'hC3, 3'd7);
        exp_done(2'b01, 1'b0, 4'd5);
        set_req(0, 8'h21, 8'hC3, 3'd7);
        wait_done(0);
        rv[0] = 1'b0;

        // Reset during WAIT drops the transaction silently
        resp_mode = 1;
        exp_write(2'b10, 8'h80, 8'h5A, 3'd4);
        set_req(1, 8'h80, 8'h5A, 3'd4);
        wait_wv();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        rv[1] = 1'b0;
        @(negedge clock);
        chk("midreset_grant", 32'(grant), 32'd0);
        chk("midreset_write_valid", 32'(write_valid), 32'd0);
        chk("midreset_req_done", 32'(req_done), 32'd0);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        resp_mode = 0;
        exp_write(2'b01, 8'h01, 8'h10, 3'd1);
        exp_write(2'b10, 8'h02, 8'h20, 3'd2);
        exp_done(2'b01, 1'b1, 4'd2);
        exp_done(2'b10, 1'b1, 4'd2);
        set_req(0, 8'h01, 8'h10, 3'd1);
        set_req(1, 8'h02, 8'h20, 3'd2);
        wait_done(0);
        rv[0] = 1'b0;
        wait_done(1);
        rv[1] = 1'b0;

        // Requester drops valid and changes data during WAIT
        resp_mode = 1;
        exp_write(2'b01, 8'h77, 8'h99, 3'd2);
        exp_done(2'b01, 1'b0, 4'd5);
        set_req(0, 8'h77, 8'h99, 3'd2);
        wait_wv();
        @(negedge clock);
        rv[0] = 1'b0;
        rd[0] = 8'h11;
        @(negedge clock);
        chk("held_write_data", 32'(write_data), 32'h99);
        wait_done(0);

        repeat (4) @(negedge clock);
        chk("write_queue_drained", 32'(wr_exp_q.size()), 32'd0);
        chk("done_queue_drained", 32'(done_exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
